// File: rtl/sar_logic.sv
// sar_logic -- successive-approximation control for the SAR ADC.
//
// The block synchronizes the sample phase from clk_gen. On the end of tracking
// it runs an MSB-first binary search that uses the comparator decision. The
// finished word is presented on a valid/ready handshake.
//
// Ports:
//   clk_ready    in   bit-cycling clock, all state changes on its rising edge
//   reset_n      in   asynchronous active-low reset
//   clk_sample   in   sample phase (high = tracking), asynchronous to clk_ready
//   comp_out     in   comparator decision, 1 = Vin >= DAC(trial code)
//   dac_code     out  trial code driven to the capacitive DAC
//   busy         out  high while converting
//   result       out  last completed conversion word
//   result_valid out  result holds an unconsumed word
//   result_ready in   consumer accepts result when valid & ready
//   overrun      out  sticky: a completed word overwrote an unconsumed one
//   abort        out  one-cycle pulse: conversion cut short by a new sample phase
module sar_logic #(
  parameter int num_bits = 4
) (
  input  logic                clk_ready,
  input  logic                reset_n,
  input  logic                clk_sample,
  input  logic                comp_out,
  output logic [num_bits-1:0] dac_code,
  output logic                busy,
  output logic [num_bits-1:0] result,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                overrun,
  output logic                abort
);

  localparam int IW = (num_bits > 2) ? $clog2(num_bits) : 1;
  localparam logic [num_bits-1:0] MSB_ONLY = {1'b1, {(num_bits-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_CONV} state_e;

  state_e              state_q;
  logic                smp_m_q, smp_s_q, smp_d_q;
  logic [num_bits-1:0] dac_q, res_q, code_d;
  logic [IW-1:0]       bit_q;
  logic                busy_q, valid_q, ovr_q, abort_q;
  logic                smp_fall, smp_rise;

  assign smp_fall = smp_d_q & ~smp_s_q;
  assign smp_rise = ~smp_d_q & smp_s_q;

  // Resolve the current bit from the comparator, then arm the next lower trial bit.
  always_comb begin
    code_d = dac_q;
    for (int i = 0; i < num_bits; i++) begin
      if (i == int'(bit_q))          code_d[i] = comp_out;
      else if (i + 1 == int'(bit_q)) code_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk_ready or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      smp_m_q <= 1'b0;
      smp_s_q <= 1'b0;
      smp_d_q <= 1'b0;
      dac_q   <= '0;
      res_q   <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      smp_m_q <= clk_sample;
      smp_s_q <= smp_m_q;
      smp_d_q <= smp_s_q;
      abort_q <= 1'b0;
      if (valid_q && result_ready) valid_q <= 1'b0;
      case (state_q)
        S_IDLE, S_SAMPLE: begin
          if (smp_fall) begin
            state_q <= S_CONV;
            dac_q   <= MSB_ONLY;
            bit_q   <= IW'(num_bits - 1);
            busy_q  <= 1'b1;
          end else if (state_q == S_IDLE && smp_s_q) begin
            state_q <= S_SAMPLE;
          end
        end
        S_CONV: begin
          // A new tracking phase wins over the decision, even on the last bit.
          if (smp_rise) begin
            state_q <= S_SAMPLE;
            dac_q   <= '0;
            busy_q  <= 1'b0;
            abort_q <= 1'b1;
          end else if (bit_q == '0) begin
            state_q <= S_IDLE;
            dac_q   <= '0;
            busy_q  <= 1'b0;
            res_q   <= code_d;
            // The completion overrides the clear above. A word that is accepted on
            // this same edge is not lost, so overrun is not set for it.
            valid_q <= 1'b1;
            if (valid_q && !result_ready) ovr_q <= 1'b1;
          end else begin
            dac_q <= code_d;
            bit_q <= bit_q - IW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dac_code     = dac_q;
  assign busy         = busy_q;
  assign result       = res_q;
  assign result_valid = valid_q;
  assign overrun      = ovr_q;
  assign abort        = abort_q;

endmodule
